// File: rtl/pipeline_controller.sv
// Stage sequencer for the 5-stage core: turns hazards, redirects, halt/resume and the
// dmem req/gnt/rvalid handshake into per-stage enables and bubble controls.
// state    | meaning
// BOOT     | first cycle after reset; every stage held and bubbled
// RUN      | normal issue, hazard and redirect arbitration
// MEM_WAIT | granted dmem access outstanding, pipeline frozen until rvalid
// DRAIN    | EBREAK held in ID while EX/MEM/WB retire
// HALT     | core stopped, waiting for resume
// ERROR    | dmem response never arrived; sticky until reset
module pipeline_controller #(
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 stall_id_i,
  input  logic                 stall_ex_i,
  input  logic                 branch_taken_i,
  input  logic                 jump_id_i,
  input  logic                 halt_req_i,
  input  logic                 resume_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  output logic                 en_if_o,
  output logic                 en_id_o,
  output logic                 en_ex_o,
  output logic                 en_mem_o,
  output logic                 en_wb_o,
  output logic                 flush_id_o,
  output logic                 flush_ex_o,
  output logic                 flush_mem_o,
  output logic                 halted_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  localparam int unsigned      DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [15:0]      TMO_LAST   = 16'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_BOOT, ST_RUN, ST_MEM_WAIT, ST_DRAIN, ST_HALT, ST_ERROR
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          tmo_q, tmo_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 ret_drain_q, ret_drain_d;
  logic                 mask_q, mask_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic [4:0]           en;     // {if, id, ex, mem, wb}
  logic [2:0]           flush;  // {id, ex, mem}
  logic                 drain_adv;
  logic                 stall_evt, flush_evt;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    drain_d     = drain_q;
    ret_drain_d = ret_drain_q;
    mask_d      = 1'b0;
    en          = 5'b00000;
    flush       = 3'b000;
    drain_adv   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        flush   = 3'b111;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (dmem_req_i) begin
          if (dmem_gnt_i) begin
            state_d     = ST_MEM_WAIT;
            tmo_d       = '0;
            ret_drain_d = 1'b0;
          end
        end else if (branch_taken_i) begin
          en    = 5'b11111;
          flush = 3'b110;
        end else if (stall_ex_i) begin
          en    = 5'b00011;
          flush = 3'b001;
        end else if (stall_id_i) begin
          en    = 5'b00111;
          flush = 3'b010;
        end else if (jump_id_i) begin
          en    = 5'b11111;
          flush = 3'b100;
        end else if (halt_req_i && !mask_q) begin
          en      = 5'b00111;
          flush   = 3'b010;
          drain_d = DRAIN_LOAD;
          state_d = ST_DRAIN;
        end else begin
          en = 5'b11111;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_rvalid_i) begin
          if (ret_drain_q) begin
            drain_adv = 1'b1;
          end else begin
            en      = 5'b11111;
            state_d = ST_RUN;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (dmem_req_i) begin
          if (dmem_gnt_i) begin
            state_d     = ST_MEM_WAIT;
            tmo_d       = '0;
            ret_drain_d = 1'b1;
          end
        end else begin
          drain_adv = 1'b1;
        end
      end
      ST_HALT: begin
        if (resume_i) begin
          state_d = ST_RUN;
          mask_d  = 1'b1;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_BOOT;
    endcase
    // The EBREAK stays parked in ID while older instructions retire.
    if (drain_adv) begin
      en    = 5'b00111;
      flush = 3'b010;
      if (drain_q == '0) begin
        state_d = ST_HALT;
      end else begin
        state_d = ST_DRAIN;
        drain_d = drain_q - 1'b1;
      end
    end
  end

  always_comb begin
    stall_evt   = !en[4] && (state_q inside {ST_RUN, ST_MEM_WAIT, ST_DRAIN});
    flush_evt   = (|flush) && (state_q != ST_BOOT);
    stall_cnt_d = (stall_evt && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush_evt && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_BOOT;
      tmo_q       <= '0;
      drain_q     <= '0;
      ret_drain_q <= 1'b0;
      mask_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      drain_q     <= drain_d;
      ret_drain_q <= ret_drain_d;
      mask_q      <= mask_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign {en_if_o, en_id_o, en_ex_o, en_mem_o, en_wb_o} = en;
  assign {flush_id_o, flush_ex_o, flush_mem_o}          = flush;
  assign halted_o    = (state_q == ST_HALT);
  assign err_o       = (state_q == ST_ERROR);
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: two instances (default and short-timeout/narrow-counter)
// checked every cycle against a phase-level reference model, directed steps then random.
module tb_pipeline_controller;

  localparam int unsigned TMO_A = 255;
  localparam int unsigned TMO_B = 4;
  localparam int unsigned CW_A  = 32;
  localparam int unsigned CW_B  = 4;
  localparam int unsigned DRAIN = 3;
  localparam longint      CAP_A = longint'((64'd1 << CW_A) - 64'd1);
  localparam longint      CAP_B = longint'((64'd1 << CW_B) - 64'd1);

  typedef struct packed {
    logic stall_id, stall_ex, branch, jump, halt, resume, req, gnt, rvalid;
  } in_t;

  typedef enum {M_BOOT, M_RUN, M_WAIT, M_DRAIN, M_HALT, M_ERR} phase_t;

  typedef struct {
    phase_t      phase;
    int unsigned waited;
    int unsigned left;
    bit          mask;
    bit          to_drain;
    longint      stalls;
    longint      flushes;
    logic [4:0]  en;
    logic [2:0]  fl;
  } mdl_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  in_t  in_s   = '0;

  logic en_if_a, en_id_a, en_ex_a, en_mem_a, en_wb_a, fl_id_a, fl_ex_a, fl_mem_a, halted_a, err_a;
  logic en_if_b, en_id_b, en_ex_b, en_mem_b, en_wb_b, fl_id_b, fl_ex_b, fl_mem_b, halted_b, err_b;
  logic [CW_A-1:0] stall_cnt_a, flush_cnt_a;
  logic [CW_B-1:0] stall_cnt_b, flush_cnt_b;

  int   vectors     = 0;
  int   miscompares = 0;
  mdl_t ma, mb;

  always #5 clk_i = ~clk_i;

  pipeline_controller #(.CNT_WIDTH(CW_A), .MEM_TIMEOUT(TMO_A), .DRAIN_CYCLES(DRAIN)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .stall_id_i(in_s.stall_id), .stall_ex_i(in_s.stall_ex), .branch_taken_i(in_s.branch),
    .jump_id_i(in_s.jump), .halt_req_i(in_s.halt), .resume_i(in_s.resume),
    .dmem_req_i(in_s.req), .dmem_gnt_i(in_s.gnt), .dmem_rvalid_i(in_s.rvalid),
    .en_if_o(en_if_a), .en_id_o(en_id_a), .en_ex_o(en_ex_a), .en_mem_o(en_mem_a), .en_wb_o(en_wb_a),
    .flush_id_o(fl_id_a), .flush_ex_o(fl_ex_a), .flush_mem_o(fl_mem_a),
    .halted_o(halted_a), .err_o(err_a), .stall_cnt_o(stall_cnt_a), .flush_cnt_o(flush_cnt_a)
  );

  pipeline_controller #(.CNT_WIDTH(CW_B), .MEM_TIMEOUT(TMO_B), .DRAIN_CYCLES(DRAIN)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .stall_id_i(in_s.stall_id), .stall_ex_i(in_s.stall_ex), .branch_taken_i(in_s.branch),
    .jump_id_i(in_s.jump), .halt_req_i(in_s.halt), .resume_i(in_s.resume),
    .dmem_req_i(in_s.req), .dmem_gnt_i(in_s.gnt), .dmem_rvalid_i(in_s.rvalid),
    .en_if_o(en_if_b), .en_id_o(en_id_b), .en_ex_o(en_ex_b), .en_mem_o(en_mem_b), .en_wb_o(en_wb_b),
    .flush_id_o(fl_id_b), .flush_ex_o(fl_ex_b), .flush_mem_o(fl_mem_b),
    .halted_o(halted_b), .err_o(err_b), .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b)
  );

  function automatic mdl_t mreset();
    mdl_t r;
    r.phase = M_BOOT; r.waited = 0; r.left = 0; r.mask = 1'b0; r.to_drain = 1'b0;
    r.stalls = 0; r.flushes = 0; r.en = '0; r.fl = '0;
    return r;
  endfunction

  // Returns the successor; r.en / r.fl hold the expected outputs for the cycle of m.
  function automatic mdl_t mstep(mdl_t m, in_t i, int unsigned tmo, longint cap);
    mdl_t r   = m;
    bit   adv = 1'b0;
    r.en = '0; r.fl = '0; r.mask = 1'b0;
    case (m.phase)
      M_BOOT: begin r.fl = 3'b111; r.phase = M_RUN; end
      M_RUN: begin
        if (i.req) begin
          if (i.gnt) begin r.phase = M_WAIT; r.waited = 0; r.to_drain = 1'b0; end
        end
        else if (i.branch)   begin r.en = 5'b11111; r.fl = 3'b110; end
        else if (i.stall_ex) begin r.en = 5'b00011; r.fl = 3'b001; end
        else if (i.stall_id) begin r.en = 5'b00111; r.fl = 3'b010; end
        else if (i.jump)     begin r.en = 5'b11111; r.fl = 3'b100; end
        else if (i.halt && !m.mask) begin
          r.en = 5'b00111; r.fl = 3'b010; r.phase = M_DRAIN; r.left = DRAIN;
        end
        else r.en = 5'b11111;
      end
      M_WAIT: begin
        if (i.rvalid) begin
          if (m.to_drain) adv = 1'b1;
          else begin r.en = 5'b11111; r.phase = M_RUN; end
        end else begin
          r.waited = m.waited + 1;
          if (r.waited >= tmo) r.phase = M_ERR;
        end
      end
      M_DRAIN: begin
        if (i.req) begin
          if (i.gnt) begin r.phase = M_WAIT; r.waited = 0; r.to_drain = 1'b1; end
        end else adv = 1'b1;
      end
      M_HALT: if (i.resume) begin r.phase = M_RUN; r.mask = 1'b1; end
      default: ;
    endcase
    if (adv) begin
      r.en = 5'b00111; r.fl = 3'b010;
      r.left = m.left - 1;
      r.phase = (r.left == 0) ? M_HALT : M_DRAIN;
    end
    if (!r.en[4] && (m.phase inside {M_RUN, M_WAIT, M_DRAIN}) && m.stalls < cap)
      r.stalls = m.stalls + 1;
    if ((r.fl != 3'b000) && m.phase != M_BOOT && m.flushes < cap)
      r.flushes = m.flushes + 1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input in_t i);
    mdl_t ra, rb;
    in_s = i;
    @(negedge clk_i);
    if (!rst_ni) begin ma = mreset(); mb = mreset(); end
    ra = mstep(ma, i, TMO_A, CAP_A);
    rb = mstep(mb, i, TMO_B, CAP_B);
    chk("a.en",     64'({en_if_a, en_id_a, en_ex_a, en_mem_a, en_wb_a}), 64'(ra.en));
    chk("a.flush",  64'({fl_id_a, fl_ex_a, fl_mem_a}), 64'(ra.fl));
    chk("a.halted", 64'(halted_a), 64'(ma.phase == M_HALT));
    chk("a.err",    64'(err_a), 64'(ma.phase == M_ERR));
    chk("a.stall_cnt", 64'(stall_cnt_a), 64'(ma.stalls));
    chk("a.flush_cnt", 64'(flush_cnt_a), 64'(ma.flushes));
    chk("b.en",     64'({en_if_b, en_id_b, en_ex_b, en_mem_b, en_wb_b}), 64'(rb.en));
    chk("b.flush",  64'({fl_id_b, fl_ex_b, fl_mem_b}), 64'(rb.fl));
    chk("b.halted", 64'(halted_b), 64'(mb.phase == M_HALT));
    chk("b.err",    64'(err_b), 64'(mb.phase == M_ERR));
    chk("b.stall_cnt", 64'(stall_cnt_b), 64'(mb.stalls));
    chk("b.flush_cnt", 64'(flush_cnt_b), 64'(mb.flushes));
    if (rst_ni) begin ma = ra; mb = rb; end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    step('0);
    step('0);
    rst_ni = 1'b1;
  endtask

  function automatic in_t mk(bit sid, bit sex, bit br, bit jmp, bit hlt, bit res, bit rq, bit gn, bit rv);
    in_t v;
    v = '{stall_id: sid, stall_ex: sex, branch: br, jump: jmp, halt: hlt,
          resume: res, req: rq, gnt: gn, rvalid: rv};
    return v;
  endfunction

  function automatic in_t rnd_in();
    in_t v;
    v.stall_id = ($urandom_range(0, 5) == 0);
    v.stall_ex = ($urandom_range(0, 5) == 0);
    v.branch   = ($urandom_range(0, 6) == 0);
    v.jump     = ($urandom_range(0, 6) == 0);
    v.halt     = ($urandom_range(0, 9) == 0);
    v.resume   = ($urandom_range(0, 3) == 0);
    v.req      = ($urandom_range(0, 5) == 0);
    v.gnt      = ($urandom_range(0, 2) != 0);
    v.rvalid   = ($urandom_range(0, 2) == 0);
    return v;
  endfunction

  initial begin
    in_t idle;
    idle = '0;
    ma = mreset();
    mb = mreset();

    // Reset release, then one BOOT cycle and normal RUN.
    do_reset();
    step(idle);
    step(idle);
    chk("boot.stall_cnt", 64'(stall_cnt_a), 64'd0);

    // Load-use stall, then branch overriding a stall.
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("stall_ex.stall_cnt", 64'(stall_cnt_a), 64'd1);
    chk("stall_ex.flush_cnt", 64'(flush_cnt_a), 64'd1);
    step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    chk("branch.flush_cnt", 64'(flush_cnt_a), 64'd2);

    // Granted access with four wait cycles; the short-timeout instance errors out.
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
    repeat (4) step(idle);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("memwait.stall_cnt", 64'(stall_cnt_a), 64'd6);
    chk("timeout.err", 64'(err_b), 64'd1);
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("timeout.sticky", 64'(err_b), 64'd1);

    // Halt with an idle memory, resume with halt_req still high.
    do_reset();
    step(idle);
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    step(idle);
    step(idle);
    chk("drain.not_yet", 64'(halted_a), 64'd0);
    step(idle);
    chk("drain.halted", 64'(halted_a), 64'd1);
    chk("drain.stall_cnt", 64'(stall_cnt_a), 64'd4);
    step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    chk("resume.masked", 64'(halted_a), 64'd0);
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    repeat (3) step(idle);

    // Halt with a data access granted during drain.
    do_reset();
    step(idle);
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
    step(idle);
    step(idle);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(idle);
    chk("drain_mem.not_yet", 64'(halted_a), 64'd0);
    step(idle);
    chk("drain_mem.halted", 64'(halted_a), 64'd1);

    // Counter saturation on the narrow instance.
    do_reset();
    step(idle);
    repeat (20) step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("sat.stall_b", 64'(stall_cnt_b), 64'd15);
    chk("sat.flush_b", 64'(flush_cnt_b), 64'd15);
    chk("sat.stall_a", 64'(stall_cnt_a), 64'd20);

    // Randomized traffic, each burst entered through a reset from an arbitrary state.
    for (int blk = 0; blk < 30; blk++) begin
      do_reset();
      for (int n = 0; n < 60; n++) step(rnd_in());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
